// File: rtl/popcount_seq.sv
// Multi-cycle population counter: counts ones (or zeros) in an 8/16/32/WIDTH-bit
// slice of the operand, CHUNK bits per cycle, stopping early once no set bits remain.
module popcount_seq #(
  parameter  int WIDTH = 32,
  parameter  int CHUNK = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inp,
  input  logic [1:0]       size,
  input  logic             count_zeros,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    result,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    result_q, result_d;

  int               activeWidth;
  logic [WIDTH-1:0] sliceMask;
  logic [CW-1:0]    chunkCount;
  logic [CW-1:0]    accSum;
  logic [WIDTH-1:0] shifted;

  // Slice width selected by size, clamped so small WIDTH builds stay in range.
  always_comb begin
    activeWidth = WIDTH;
    case (size)
      2'b00:   activeWidth = 8;
      2'b01:   activeWidth = 16;
      2'b10:   activeWidth = 32;
      default: activeWidth = WIDTH;
    endcase
    if (activeWidth > WIDTH) begin
      activeWidth = WIDTH;
    end
    for (int i = 0; i < WIDTH; i++) begin
      sliceMask[i] = (i < activeWidth);
    end
  end

  always_comb begin
    chunkCount = '0;
    for (int i = 0; i < CHUNK; i++) begin
      chunkCount = chunkCount + CW'(shreg_q[i]);
    end
    accSum  = acc_q + chunkCount;
    shifted = shreg_q >> CHUNK;
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shreg_d = (count_zeros ? ~inp : inp) & sliceMask;
          acc_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d   = accSum;
        shreg_d = shifted;
        // Early exit: once the remaining bits are all zero the count is final.
        if (shifted == '0) begin
          state_d  = DONE;
          result_d = accSum;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == BUSY) || (state_q == DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_popcount_seq.sv
// Self-checking bench for popcount_seq (WIDTH=32, CHUNK=8): directed vector table,
// backpressure and mid-operation reset sequences, then randomized ops against a model.
module tb_popcount_seq;

  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int CW    = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] inp;
  logic [1:0]       size;
  logic             count_zeros;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    result;
  logic             busy;

  int checkCount = 0;
  int passCount  = 0;

  typedef struct {
    logic [1:0]  size;
    logic        cz;
    logic [31:0] inp;
    int          expRes;
    int          expLat;
  } vec_t;

  vec_t vecs[8];

  popcount_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .inp        (inp),
    .size       (size),
    .count_zeros(count_zeros),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference: mask the slice arithmetically, count bits, and find how many
  // CHUNK-sized groups reach the highest set bit.
  function automatic void model(input logic [1:0] sz, input logic cz, input logic [31:0] x,
                                output int cnt, output int lat);
    int aw;
    longint unsigned v;
    aw = 8 << sz;
    if (aw > WIDTH) aw = WIDTH;
    v = cz ? {32'd0, ~x} : {32'd0, x};
    v = v & ((64'd1 << aw) - 64'd1);
    cnt = $countones(v);
    lat = 0;
    while (v != 0) begin
      lat++;
      v = v >> CHUNK;
    end
    if (lat == 0) lat = 1;
  endfunction

  // Called #1 after a posedge; presents the operand and lets the next edge accept it.
  task automatic applyStimulus(input logic [1:0] sz, input logic cz, input logic [31:0] x,
                               input string name);
    size        = sz;
    count_zeros = cz;
    inp         = x;
    in_valid    = 1'b1;
    checkOutput({name, " in_ready"}, int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    inp      = $urandom;
    size     = 2'($urandom);
  endtask

  task automatic waitResult(input int expRes, input int expLat, input string name);
    int lat;
    lat = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (lat == 0) begin
        @(posedge clk); #1;
        if (out_valid) lat = cyc;
      end
    end
    checkOutput({name, " latency"}, lat, expLat);
    checkOutput({name, " result"}, int'(result), expRes);
  endtask

  task automatic releaseResult(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({name, " out_valid drop"}, int'(out_valid), 0);
  endtask

  initial begin
    int cnt, lat;
    logic [1:0]  rs;
    logic        rc;
    logic [31:0] rx;

    vecs[0] = '{2'b10, 1'b0, 32'hFFFF_FFFF, 32, 4};
    vecs[1] = '{2'b01, 1'b0, 32'hFFFF_00F0, 4, 1};
    vecs[2] = '{2'b00, 1'b1, 32'h0000_0081, 6, 1};
    vecs[3] = '{2'b10, 1'b0, 32'h0000_0000, 0, 1};
    vecs[4] = '{2'b10, 1'b1, 32'h0000_0000, 32, 4};
    vecs[5] = '{2'b11, 1'b0, 32'h8000_0000, 1, 4};
    vecs[6] = '{2'b10, 1'b0, 32'h0001_0000, 1, 3};
    vecs[7] = '{2'b01, 1'b1, 32'h0000_FF00, 8, 1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    inp = '0; size = '0; count_zeros = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset in_ready", int'(in_ready), 0);
    checkOutput("reset out_valid", int'(out_valid), 0);
    checkOutput("reset result", int'(result), 0);
    checkOutput("reset busy", int'(busy), 0);
    rst_n = 1'b1;
    #1;
    checkOutput("post-reset in_ready", int'(in_ready), 1);

    for (int i = 0; i < 8; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      applyStimulus(vecs[i].size, vecs[i].cz, vecs[i].inp, nm);
      waitResult(vecs[i].expRes, vecs[i].expLat, nm);
      releaseResult(nm);
    end

    // Backpressure: DONE held with a competing operand waiting upstream.
    applyStimulus(2'b10, 1'b0, 32'h0F0F_0F0F, "bp");
    waitResult(16, 4, "bp");
    in_valid = 1'b1; inp = 32'h0000_0003; size = 2'b00; count_zeros = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checkOutput("bp hold out_valid", int'(out_valid), 1);
      checkOutput("bp hold in_ready", int'(in_ready), 0);
      checkOutput("bp hold result", int'(result), 16);
      checkOutput("bp hold busy", int'(busy), 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("bp release out_valid", int'(out_valid), 0);
    checkOutput("bp release result held", int'(result), 16);
    applyStimulus(2'b00, 1'b0, 32'h0000_0003, "bp next");
    waitResult(2, 1, "bp next");
    releaseResult("bp next");

    // Reset during BUSY abandons the operation.
    applyStimulus(2'b10, 1'b0, 32'hFFFF_FFFF, "rst");
    @(posedge clk); #1;
    checkOutput("rst busy before", int'(busy), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst out_valid", int'(out_valid), 0);
    checkOutput("rst result", int'(result), 0);
    checkOutput("rst in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    applyStimulus(2'b00, 1'b0, 32'h0000_00FF, "rst after");
    waitResult(8, 1, "rst after");
    releaseResult("rst after");

    for (int r = 0; r < 40; r++) begin
      rs = 2'($urandom);
      rc = 1'($urandom);
      rx = $urandom;
      if (r % 4 == 1) rx = rx >> (($urandom % 4) * 8);
      model(rs, rc, rx, cnt, lat);
      applyStimulus(rs, rc, rx, $sformatf("rand%0d", r));
      waitResult(cnt, lat, $sformatf("rand%0d", r));
      releaseResult($sformatf("rand%0d", r));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
